lsu_queue: RTL and testbench
============================

Name: lsu_queue

Overview:
- In-order load/store queue between dispatch and `dmem_read_write_unit`.
- Accepts memory ops from dispatch and holds them in a circular buffer.
- Each entry snoops two CDBs until its operands resolve.
- Presents the head entry to the dmem read/write unit using that unit's existing `lsu_*` handshake.
- Marks wrong-path speculative entries as squashed so the downstream unit pops and drops them without a memory access.

Parameters:
- DEPTH, 8, number of queue entries; must be a power of 2 and at least 2.

Ports:
- clk_i  in  1  clock
- reset_ni  in  1  reset, asynchronous, active-low
- disp_valid_i  in  1  dispatch presents a memory op this cycle
- disp_ready_o  out  1  queue can accept a dispatch (not full)
- disp_load_i  in  1  1 = load, 0 = store
- disp_ld_tag_i  in  rs_tag_t  destination tag of a load
- disp_base_tag_i  in  rs_tag_t  base operand tag; NO_VAL means the value is valid
- disp_base_val_i  in  32  base operand value
- disp_data_tag_i  in  rs_tag_t  store-data operand tag; NO_VAL means valid; ignored for loads
- disp_data_val_i  in  32  store-data value
- disp_imm_i  in  32  sign-extended offset
- disp_spec_i  in  1  op was dispatched under an unresolved branch
- cdb_i  in  cdb_t  common data bus
- cdb_load_i  in  cdb_t  load result bus from `dmem_read_write_unit`
- br_resolve_i  in  1  oldest unresolved branch resolves this cycle
- br_mispredict_i  in  1  qualifies br_resolve_i: 1 = mispredicted
- lsu_read_i  in  1  pop request from the downstream unit
- lsu_empty_o  out  1  queue is empty
- lsu_instr_ready_o  out  1  head entry may be issued
- lsu_load_o  out  1  type of the head entry
- lsu_ld_tag_o  out  rs_tag_t  load tag of the head entry
- lsu_speculative_o  out  1  head entry's spec bit
- lsu_corr_pred_o  out  1  0 when the head entry is squashed
- lsu_eff_addr_o  out  32  effective address of the most recently popped entry (registered)
- lsu_st_data_o  out  32  store data of the most recently popped entry (registered)

Behaviour:
- Reset (reset_ni low, asynchronous):
  - head, tail and count cleared to 0; all entry valid bits cleared.
  - lsu_empty_o = 1; disp_ready_o = 1; lsu_instr_ready_o = 0; lsu_load_o = 0; lsu_ld_tag_o = NO_VAL.
  - lsu_speculative_o = 0; lsu_corr_pred_o = 1; issue register (lsu_eff_addr_o, lsu_st_data_o) = 0.
  - Reset asserted mid-operation discards every entry; there is no drain.
- Entry fields: load, ld_tag, base tag/val, data tag/val, imm, spec, squash, valid.
- Dispatch:
  - Write occurs when disp_valid_i & disp_ready_o.
  - disp_ready_o = (count != DEPTH); it is not relieved by a same-cycle pop.
  - If a dispatched operand tag matches cdb_i.tag or cdb_load_i.tag in the dispatch cycle, the operand is captured valid immediately.
- Snoop:
  - Every valid entry with a pending operand whose tag equals a bus tag (bus tag != NO_VAL) captures that bus's val.
  - The tag is then set to NO_VAL.
  - If both buses match the same tag, cdb_i takes priority.
- Head readiness:
  - ready = valid & base valid & (load | data valid), OR valid & squash.
  - A hold flop suppresses ready in the first cycle an entry is head, so lsu_load_o is stable for at least one cycle before ready rises (the downstream unit registers the load flag).
  - lsu_instr_ready_o = ready & ~hold.
- Pop:
  - On lsu_read_i & ~lsu_empty_o, the issue register loads addr = head.base + head.imm (mod 2^32) and data = head.data.
  - head advances and count decrements.
  - The issue outputs are valid the cycle after the pop and hold until the next pop.
  - lsu_read_i while empty is ignored.
  - A simultaneous dispatch and pop leaves count unchanged.
- Pointers wrap modulo DEPTH. count has width clog2(DEPTH)+1 so that full and empty are distinguishable.
- Branch resolve:
  - Correct prediction (br_resolve_i & ~br_mispredict_i): clear spec on all valid entries.
  - Misprediction: set squash on every valid entry with spec = 1.
  - An op dispatched in the same cycle as a resolve takes the resolve's effect (cleared spec or set squash).
- Squashed entries present ready with lsu_corr_pred_o = 0 and lsu_speculative_o = 1; the downstream unit pops them without a memory access.
- Head outputs (lsu_load_o, lsu_ld_tag_o, lsu_speculative_o, lsu_corr_pred_o) are combinational from the head entry. When empty they take their reset values.

Decomposition:
- Additions to the shared `data_types` package:
  - `lsq_entry_t` struct.
  - `lsq_ptr_t` sized by DEPTH.
- Reuse `word32_t`, `rs_tag_t`, `cdb_t` and `NO_VAL` from that package.
- One sub-module, `lsq_operand_snoop`: a combinational capture of one operand (tag/val) against two CDBs. It is instantiated per entry per operand and also on the dispatch path.

Test Plan:
- Dispatch load base=0x100 (valid), imm=0x8, tag=3; hold lsu_read_i = 0 → ready rises 2 cycles after dispatch with lsu_load_o = 1 one cycle earlier. Pulse lsu_read_i → next cycle lsu_eff_addr_o = 0x108 and lsu_empty_o = 1.
- Dispatch store whose data tag = 5 is pending → ready stays 0. Drive cdb_i = {5, 0xDEADBEEF} → ready next cycle; after pop, lsu_st_data_o = 0xDEADBEEF.
- Fill DEPTH = 8 entries → disp_ready_o = 0. Assert a dispatch and a pop in the same cycle → no write occurs, count = 7, disp_ready_o = 1. Run 20 further dispatch/pop cycles → FIFO order preserved across pointer wrap.
- Dispatch two spec loads with pending operands, then br_resolve_i = 1, br_mispredict_i = 1 → each head presents ready, speculative = 1, corr_pred = 0 without its operands. Check that an earlier non-spec entry is unaffected.
- Drive a dispatch tag that matches cdb_load_i in the same cycle → operand captured immediately. Drive cdb_i and cdb_load_i with equal tags → the cdb_i value is captured.
- Deassert reset_ni asynchronously between clock edges with 4 entries held → outputs take their reset values immediately; after release, lsu_empty_o = 1 and dispatch works.

Source files
------------

// File: rtl/data_types.sv
// data_types: shared tag/bus types plus the load/store queue entry layout
package data_types;
  localparam int TAG_W     = 5;
  localparam int LSQ_DEPTH = 8;
  typedef logic [31:0]      word32_t;
  typedef logic [TAG_W-1:0] rs_tag_t;
  localparam rs_tag_t NO_VAL = '0;
  typedef struct packed {
    rs_tag_t tag;
    word32_t val;
  } cdb_t;
  typedef logic [$clog2(LSQ_DEPTH)-1:0] lsq_ptr_t;
  typedef struct packed {
    logic    load;
    rs_tag_t ld_tag;
    rs_tag_t base_tag;
    word32_t base_val;
    rs_tag_t data_tag;
    word32_t data_val;
    word32_t imm;
    logic    spec;
    logic    squash;
    logic    valid;
  } lsq_entry_t;
endpackage

// File: rtl/lsq_operand_snoop.sv
// lsq_operand_snoop: captures one pending operand from the CDB or load bus, CDB first
module lsq_operand_snoop
  import data_types::*;
(
  input  rs_tag_t i_tag,
  input  word32_t i_val,
  input  cdb_t    i_cdb,
  input  cdb_t    i_cdb_load,
  output rs_tag_t o_tag,
  output word32_t o_val
);
  logic w_hit_cdb, w_hit_load;
  assign w_hit_cdb  = (i_tag != NO_VAL) && (i_cdb.tag == i_tag);
  assign w_hit_load = (i_tag != NO_VAL) && (i_cdb_load.tag == i_tag);
  assign o_tag = (w_hit_cdb || w_hit_load) ? NO_VAL : i_tag;
  assign o_val = w_hit_cdb ? i_cdb.val : w_hit_load ? i_cdb_load.val : i_val;
endmodule

// File: rtl/lsu_queue.sv
// lsu_queue: in-order load/store queue feeding the dmem read/write unit
// through its lsu_* handshake, with operand snooping and branch squash.
module lsu_queue
  import data_types::*;
#(
  parameter int DEPTH = LSQ_DEPTH
) (
  input  logic    clk_i,
  input  logic    reset_ni,
  input  logic    disp_valid_i,
  output logic    disp_ready_o,
  input  logic    disp_load_i,
  input  rs_tag_t disp_ld_tag_i,
  input  rs_tag_t disp_base_tag_i,
  input  word32_t disp_base_val_i,
  input  rs_tag_t disp_data_tag_i,
  input  word32_t disp_data_val_i,
  input  word32_t disp_imm_i,
  input  logic    disp_spec_i,
  input  cdb_t    cdb_i,
  input  cdb_t    cdb_load_i,
  input  logic    br_resolve_i,
  input  logic    br_mispredict_i,
  input  logic    lsu_read_i,
  output logic    lsu_empty_o,
  output logic    lsu_instr_ready_o,
  output logic    lsu_load_o,
  output rs_tag_t lsu_ld_tag_o,
  output logic    lsu_speculative_o,
  output logic    lsu_corr_pred_o,
  output word32_t lsu_eff_addr_o,
  output word32_t lsu_st_data_o
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  lsq_entry_t    r_q [DEPTH];
  logic [PW-1:0] r_head, r_tail;
  logic [PW:0]   r_count;
  logic          r_hold;
  word32_t       r_eff_addr, r_st_data;
  lsq_entry_t    w_head, w_new;
  rs_tag_t       w_base_tag [DEPTH];
  word32_t       w_base_val [DEPTH];
  rs_tag_t       w_data_tag [DEPTH];
  word32_t       w_data_val [DEPTH];
  rs_tag_t       w_nb_tag, w_nd_tag;
  word32_t       w_nb_val, w_nd_val;
  logic          w_empty, w_push, w_pop, w_ready, w_br_ok, w_br_bad;
  for (genvar i = 0; i < DEPTH; i++) begin : g_snp
    lsq_operand_snoop u_base (
      .i_tag(r_q[i].base_tag), .i_val(r_q[i].base_val), .i_cdb(cdb_i), .i_cdb_load(cdb_load_i),
      .o_tag(w_base_tag[i]), .o_val(w_base_val[i])
    );
    lsq_operand_snoop u_data (
      .i_tag(r_q[i].data_tag), .i_val(r_q[i].data_val), .i_cdb(cdb_i), .i_cdb_load(cdb_load_i),
      .o_tag(w_data_tag[i]), .o_val(w_data_val[i])
    );
  end
  lsq_operand_snoop u_disp_base (
    .i_tag(disp_base_tag_i), .i_val(disp_base_val_i), .i_cdb(cdb_i), .i_cdb_load(cdb_load_i),
    .o_tag(w_nb_tag), .o_val(w_nb_val)
  );
  lsq_operand_snoop u_disp_data (
    .i_tag(disp_data_tag_i), .i_val(disp_data_val_i), .i_cdb(cdb_i), .i_cdb_load(cdb_load_i),
    .o_tag(w_nd_tag), .o_val(w_nd_val)
  );
  assign w_empty  = (r_count == '0);
  assign w_push   = disp_valid_i && disp_ready_o;
  assign w_pop    = lsu_read_i && !w_empty;
  assign w_br_ok  = br_resolve_i && !br_mispredict_i;
  assign w_br_bad = br_resolve_i && br_mispredict_i;
  assign w_head   = r_q[r_head];
  // A resolve in the dispatch cycle applies to the incoming op as well.
  always_comb begin
    w_new = '{load: disp_load_i, ld_tag: disp_ld_tag_i, base_tag: w_nb_tag, base_val: w_nb_val,
              data_tag: w_nd_tag, data_val: w_nd_val, imm: disp_imm_i,
              spec: disp_spec_i && !w_br_ok, squash: disp_spec_i && w_br_bad, valid: 1'b1};
  end
  assign w_ready = w_head.valid && (w_head.squash ||
                   (w_head.base_tag == NO_VAL && (w_head.load || w_head.data_tag == NO_VAL)));
  assign disp_ready_o      = (r_count != FULL);
  assign lsu_empty_o       = w_empty;
  assign lsu_instr_ready_o = w_ready && !r_hold;
  assign lsu_load_o        = !w_empty && w_head.load;
  assign lsu_ld_tag_o      = w_empty ? NO_VAL : w_head.ld_tag;
  assign lsu_speculative_o = !w_empty && w_head.spec;
  assign lsu_corr_pred_o   = w_empty || !w_head.squash;
  assign lsu_eff_addr_o    = r_eff_addr;
  assign lsu_st_data_o     = r_st_data;
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int k = 0; k < DEPTH; k++) r_q[k] <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_hold     <= 1'b0;
      r_eff_addr <= '0;
      r_st_data  <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (r_q[k].valid) begin
          r_q[k].base_tag <= w_base_tag[k];
          r_q[k].base_val <= w_base_val[k];
          r_q[k].data_tag <= w_data_tag[k];
          r_q[k].data_val <= w_data_val[k];
          r_q[k].spec     <= r_q[k].spec && !w_br_ok;
          r_q[k].squash   <= r_q[k].squash || (w_br_bad && r_q[k].spec);
        end
      end
      if (w_pop) begin
        r_q[r_head].valid <= 1'b0;
        r_head            <= r_head + 1'b1;
        r_eff_addr        <= w_head.base_val + w_head.imm;
        r_st_data         <= w_head.data_val;
      end
      if (w_push) begin
        r_q[r_tail] <= w_new;
        r_tail      <= r_tail + 1'b1;
      end
      r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
      // New head appears after a pop or a dispatch into an empty queue.
      r_hold  <= w_pop || (w_push && w_empty);
    end
  end
endmodule

// File: tb/tb_lsu_queue.sv
// tb_lsu_queue: directed scenario tests for lsu_queue
module tb_lsu_queue;
  import data_types::*;
  logic clk_i = 1'b0, reset_ni;
  logic disp_valid_i, disp_ready_o, disp_load_i, disp_spec_i;
  rs_tag_t disp_ld_tag_i, disp_base_tag_i, disp_data_tag_i, lsu_ld_tag_o;
  word32_t disp_base_val_i, disp_data_val_i, disp_imm_i, lsu_eff_addr_o, lsu_st_data_o;
  cdb_t cdb_i, cdb_load_i;
  logic br_resolve_i, br_mispredict_i, lsu_read_i;
  logic lsu_empty_o, lsu_instr_ready_o, lsu_load_o, lsu_speculative_o, lsu_corr_pred_o;
  int n_cmp = 0, n_bad = 0;
  word32_t exp_q[$];
  word32_t exp_v;
  lsu_queue #(.DEPTH(8)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .disp_valid_i(disp_valid_i), .disp_ready_o(disp_ready_o), .disp_load_i(disp_load_i),
    .disp_ld_tag_i(disp_ld_tag_i), .disp_base_tag_i(disp_base_tag_i), .disp_base_val_i(disp_base_val_i),
    .disp_data_tag_i(disp_data_tag_i), .disp_data_val_i(disp_data_val_i), .disp_imm_i(disp_imm_i),
    .disp_spec_i(disp_spec_i), .cdb_i(cdb_i), .cdb_load_i(cdb_load_i),
    .br_resolve_i(br_resolve_i), .br_mispredict_i(br_mispredict_i), .lsu_read_i(lsu_read_i),
    .lsu_empty_o(lsu_empty_o), .lsu_instr_ready_o(lsu_instr_ready_o), .lsu_load_o(lsu_load_o),
    .lsu_ld_tag_o(lsu_ld_tag_o), .lsu_speculative_o(lsu_speculative_o), .lsu_corr_pred_o(lsu_corr_pred_o),
    .lsu_eff_addr_o(lsu_eff_addr_o), .lsu_st_data_o(lsu_st_data_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic disp(input logic ld, input rs_tag_t lt, input rs_tag_t bt, input word32_t bv,
                      input rs_tag_t dt, input word32_t dv, input word32_t imm, input logic sp);
    disp_valid_i = 1'b1; disp_load_i = ld; disp_ld_tag_i = lt;
    disp_base_tag_i = bt; disp_base_val_i = bv; disp_data_tag_i = dt; disp_data_val_i = dv;
    disp_imm_i = imm; disp_spec_i = sp;
  endtask
  task automatic test_reset();
    n_cmp++; if (lsu_empty_o !== 1'b1) begin n_bad++; $display("FAIL rst_empty: got %b want 1", lsu_empty_o); end
    n_cmp++; if (disp_ready_o !== 1'b1) begin n_bad++; $display("FAIL rst_disp_ready: got %b want 1", disp_ready_o); end
    n_cmp++; if (lsu_instr_ready_o !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", lsu_instr_ready_o); end
    n_cmp++; if (lsu_load_o !== 1'b0) begin n_bad++; $display("FAIL rst_load: got %b want 0", lsu_load_o); end
    n_cmp++; if (lsu_ld_tag_o !== NO_VAL) begin n_bad++; $display("FAIL rst_ld_tag: got %h want %h", lsu_ld_tag_o, NO_VAL); end
    n_cmp++; if (lsu_speculative_o !== 1'b0) begin n_bad++; $display("FAIL rst_spec: got %b want 0", lsu_speculative_o); end
    n_cmp++; if (lsu_corr_pred_o !== 1'b1) begin n_bad++; $display("FAIL rst_corr: got %b want 1", lsu_corr_pred_o); end
    n_cmp++; if (lsu_eff_addr_o !== 32'h0) begin n_bad++; $display("FAIL rst_addr: got %h want 0", lsu_eff_addr_o); end
    n_cmp++; if (lsu_st_data_o !== 32'h0) begin n_bad++; $display("FAIL rst_data: got %h want 0", lsu_st_data_o); end
  endtask
  task automatic test_load();
    disp(1'b1, 5'd3, NO_VAL, 32'h100, NO_VAL, 32'h0, 32'h8, 1'b0);
    tick();
    disp_valid_i = 1'b0;
    n_cmp++; if (lsu_load_o !== 1'b1) begin n_bad++; $display("FAIL ld_load_early: got %b want 1", lsu_load_o); end
    n_cmp++; if (lsu_instr_ready_o !== 1'b0) begin n_bad++; $display("FAIL ld_hold: got %b want 0", lsu_instr_ready_o); end
    n_cmp++; if (lsu_ld_tag_o !== 5'd3) begin n_bad++; $display("FAIL ld_tag: got %h want 3", lsu_ld_tag_o); end
    tick();
    n_cmp++; if (lsu_instr_ready_o !== 1'b1) begin n_bad++; $display("FAIL ld_ready: got %b want 1", lsu_instr_ready_o); end
    lsu_read_i = 1'b1;
    tick();
    lsu_read_i = 1'b0;
    n_cmp++; if (lsu_eff_addr_o !== 32'h108) begin n_bad++; $display("FAIL ld_addr: got %h want 108", lsu_eff_addr_o); end
    n_cmp++; if (lsu_empty_o !== 1'b1) begin n_bad++; $display("FAIL ld_empty: got %b want 1", lsu_empty_o); end
    lsu_read_i = 1'b1;
    tick();
    lsu_read_i = 1'b0;
    n_cmp++; if (lsu_eff_addr_o !== 32'h108) begin n_bad++; $display("FAIL ld_read_empty: got %h want 108", lsu_eff_addr_o); end
  endtask
  task automatic test_store_snoop();
    disp(1'b0, NO_VAL, NO_VAL, 32'h200, 5'd5, 32'h0, 32'h4, 1'b0);
    tick();
    disp_valid_i = 1'b0;
    tick(); tick();
    n_cmp++; if (lsu_instr_ready_o !== 1'b0) begin n_bad++; $display("FAIL st_pending: got %b want 0", lsu_instr_ready_o); end
    cdb_i = '{tag: 5'd5, val: 32'hDEADBEEF};
    tick();
    cdb_i = '0;
    n_cmp++; if (lsu_instr_ready_o !== 1'b1) begin n_bad++; $display("FAIL st_ready: got %b want 1", lsu_instr_ready_o); end
    lsu_read_i = 1'b1;
    tick();
    lsu_read_i = 1'b0;
    n_cmp++; if (lsu_st_data_o !== 32'hDEADBEEF) begin n_bad++; $display("FAIL st_data: got %h want deadbeef", lsu_st_data_o); end
    n_cmp++; if (lsu_eff_addr_o !== 32'h204) begin n_bad++; $display("FAIL st_addr: got %h want 204", lsu_eff_addr_o); end
  endtask
  task automatic test_full_wrap();
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      disp(1'b1, 5'(i + 1), NO_VAL, 32'(i * 16), NO_VAL, 32'h0, 32'h3, 1'b0);
      exp_q.push_back(32'(i * 16) + 32'h3);
      tick();
    end
    disp_valid_i = 1'b0;
    n_cmp++; if (disp_ready_o !== 1'b0) begin n_bad++; $display("FAIL full_ready: got %b want 0", disp_ready_o); end
    disp(1'b1, 5'd9, NO_VAL, 32'h999, NO_VAL, 32'h0, 32'h0, 1'b0);
    lsu_read_i = 1'b1;
    tick();
    disp_valid_i = 1'b0; lsu_read_i = 1'b0;
    exp_v = exp_q.pop_front();
    n_cmp++; if (disp_ready_o !== 1'b1) begin n_bad++; $display("FAIL full_pop_ready: got %b want 1", disp_ready_o); end
    n_cmp++; if (lsu_eff_addr_o !== exp_v) begin n_bad++; $display("FAIL full_pop_addr: got %h want %h", lsu_eff_addr_o, exp_v); end
    for (int k = 0; k < 20; k++) begin
      disp(1'b1, 5'd2, NO_VAL, 32'h1000 + 32'(k), NO_VAL, 32'h0, 32'h10, 1'b0);
      lsu_read_i = 1'b1;
      exp_q.push_back(32'h1010 + 32'(k));
      tick();
      exp_v = exp_q.pop_front();
      n_cmp++; if (lsu_eff_addr_o !== exp_v) begin n_bad++; $display("FAIL wrap_addr[%0d]: got %h want %h", k, lsu_eff_addr_o, exp_v); end
    end
    disp_valid_i = 1'b0;
    for (int k = 0; k < 7; k++) begin
      tick();
      exp_v = exp_q.pop_front();
      n_cmp++; if (lsu_eff_addr_o !== exp_v) begin n_bad++; $display("FAIL drain_addr[%0d]: got %h want %h", k, lsu_eff_addr_o, exp_v); end
    end
    lsu_read_i = 1'b0;
    n_cmp++; if (lsu_empty_o !== 1'b1) begin n_bad++; $display("FAIL drain_empty: got %b want 1", lsu_empty_o); end
  endtask
  task automatic test_squash();
    disp(1'b1, 5'd1, 5'd7, 32'h0, NO_VAL, 32'h0, 32'h4, 1'b0);
    tick();
    disp(1'b1, 5'd2, 5'd8, 32'h0, NO_VAL, 32'h0, 32'h0, 1'b1);
    tick();
    disp(1'b1, 5'd3, 5'd9, 32'h0, NO_VAL, 32'h0, 32'h0, 1'b1);
    tick();
    disp_valid_i = 1'b0; br_resolve_i = 1'b1; br_mispredict_i = 1'b1;
    tick();
    br_resolve_i = 1'b0; br_mispredict_i = 1'b0;
    n_cmp++; if (lsu_instr_ready_o !== 1'b0) begin n_bad++; $display("FAIL sq_nonspec_ready: got %b want 0", lsu_instr_ready_o); end
    n_cmp++; if (lsu_corr_pred_o !== 1'b1) begin n_bad++; $display("FAIL sq_nonspec_corr: got %b want 1", lsu_corr_pred_o); end
    n_cmp++; if (lsu_speculative_o !== 1'b0) begin n_bad++; $display("FAIL sq_nonspec_spec: got %b want 0", lsu_speculative_o); end
    cdb_i = '{tag: 5'd7, val: 32'h40};
    tick();
    cdb_i = '0;
    n_cmp++; if (lsu_instr_ready_o !== 1'b1) begin n_bad++; $display("FAIL sq_nonspec_rdy2: got %b want 1", lsu_instr_ready_o); end
    lsu_read_i = 1'b1;
    tick();
    lsu_read_i = 1'b0;
    n_cmp++; if (lsu_eff_addr_o !== 32'h44) begin n_bad++; $display("FAIL sq_nonspec_addr: got %h want 44", lsu_eff_addr_o); end
    n_cmp++; if (lsu_instr_ready_o !== 1'b0) begin n_bad++; $display("FAIL sq_hold: got %b want 0", lsu_instr_ready_o); end
    for (int k = 0; k < 2; k++) begin
      tick();
      n_cmp++; if (lsu_instr_ready_o !== 1'b1) begin n_bad++; $display("FAIL sq_ready[%0d]: got %b want 1", k, lsu_instr_ready_o); end
      n_cmp++; if (lsu_speculative_o !== 1'b1) begin n_bad++; $display("FAIL sq_spec[%0d]: got %b want 1", k, lsu_speculative_o); end
      n_cmp++; if (lsu_corr_pred_o !== 1'b0) begin n_bad++; $display("FAIL sq_corr[%0d]: got %b want 0", k, lsu_corr_pred_o); end
      n_cmp++; if (lsu_ld_tag_o !== 5'(k + 2)) begin n_bad++; $display("FAIL sq_tag[%0d]: got %h want %h", k, lsu_ld_tag_o, 5'(k + 2)); end
      lsu_read_i = 1'b1;
      tick();
      lsu_read_i = 1'b0;
    end
    n_cmp++; if (lsu_empty_o !== 1'b1) begin n_bad++; $display("FAIL sq_empty: got %b want 1", lsu_empty_o); end
    disp(1'b1, 5'd4, NO_VAL, 32'h80, NO_VAL, 32'h0, 32'h0, 1'b1);
    tick();
    disp_valid_i = 1'b0;
    n_cmp++; if (lsu_speculative_o !== 1'b1) begin n_bad++; $display("FAIL ok_spec_before: got %b want 1", lsu_speculative_o); end
    br_resolve_i = 1'b1;
    tick();
    br_resolve_i = 1'b0;
    n_cmp++; if (lsu_speculative_o !== 1'b0) begin n_bad++; $display("FAIL ok_spec_after: got %b want 0", lsu_speculative_o); end
    n_cmp++; if (lsu_corr_pred_o !== 1'b1) begin n_bad++; $display("FAIL ok_corr: got %b want 1", lsu_corr_pred_o); end
    lsu_read_i = 1'b1;
    tick();
    lsu_read_i = 1'b0;
    n_cmp++; if (lsu_eff_addr_o !== 32'h80) begin n_bad++; $display("FAIL ok_addr: got %h want 80", lsu_eff_addr_o); end
  endtask
  task automatic test_dispatch_capture();
    disp(1'b1, 5'd1, 5'd6, 32'h0, NO_VAL, 32'h0, 32'h0, 1'b0);
    cdb_load_i = '{tag: 5'd6, val: 32'h300};
    tick();
    disp_valid_i = 1'b0; cdb_load_i = '0;
    tick();
    n_cmp++; if (lsu_instr_ready_o !== 1'b1) begin n_bad++; $display("FAIL cap_ready: got %b want 1", lsu_instr_ready_o); end
    lsu_read_i = 1'b1;
    tick();
    lsu_read_i = 1'b0;
    n_cmp++; if (lsu_eff_addr_o !== 32'h300) begin n_bad++; $display("FAIL cap_addr: got %h want 300", lsu_eff_addr_o); end
    disp(1'b1, 5'd1, 5'd10, 32'h0, NO_VAL, 32'h0, 32'h0, 1'b0);
    tick();
    disp_valid_i = 1'b0;
    cdb_i = '{tag: 5'd10, val: 32'h111};
    cdb_load_i = '{tag: 5'd10, val: 32'h222};
    tick();
    cdb_i = '0; cdb_load_i = '0;
    lsu_read_i = 1'b1;
    tick();
    lsu_read_i = 1'b0;
    n_cmp++; if (lsu_eff_addr_o !== 32'h111) begin n_bad++; $display("FAIL prio_addr: got %h want 111", lsu_eff_addr_o); end
  endtask
  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) begin
      disp(1'b1, 5'd5, NO_VAL, 32'h700, NO_VAL, 32'h0, 32'h0, 1'b1);
      tick();
    end
    disp_valid_i = 1'b0;
    #3 reset_ni = 1'b0;
    #1;
    n_cmp++; if (lsu_empty_o !== 1'b1) begin n_bad++; $display("FAIL ar_empty: got %b want 1", lsu_empty_o); end
    n_cmp++; if (lsu_load_o !== 1'b0) begin n_bad++; $display("FAIL ar_load: got %b want 0", lsu_load_o); end
    n_cmp++; if (lsu_ld_tag_o !== NO_VAL) begin n_bad++; $display("FAIL ar_tag: got %h want %h", lsu_ld_tag_o, NO_VAL); end
    n_cmp++; if (lsu_speculative_o !== 1'b0) begin n_bad++; $display("FAIL ar_spec: got %b want 0", lsu_speculative_o); end
    n_cmp++; if (lsu_eff_addr_o !== 32'h0) begin n_bad++; $display("FAIL ar_addr: got %h want 0", lsu_eff_addr_o); end
    n_cmp++; if (disp_ready_o !== 1'b1) begin n_bad++; $display("FAIL ar_disp_ready: got %b want 1", disp_ready_o); end
    @(posedge clk_i);
    #2 reset_ni = 1'b1;
    tick();
    n_cmp++; if (lsu_empty_o !== 1'b1) begin n_bad++; $display("FAIL ar_empty_after: got %b want 1", lsu_empty_o); end
    disp(1'b1, 5'd6, NO_VAL, 32'h500, NO_VAL, 32'h0, 32'h0, 1'b0);
    tick();
    disp_valid_i = 1'b0;
    n_cmp++; if (lsu_load_o !== 1'b1) begin n_bad++; $display("FAIL ar_new_load: got %b want 1", lsu_load_o); end
    tick();
    lsu_read_i = 1'b1;
    tick();
    lsu_read_i = 1'b0;
    n_cmp++; if (lsu_eff_addr_o !== 32'h500) begin n_bad++; $display("FAIL ar_new_addr: got %h want 500", lsu_eff_addr_o); end
    n_cmp++; if (lsu_empty_o !== 1'b1) begin n_bad++; $display("FAIL ar_new_empty: got %b want 1", lsu_empty_o); end
  endtask
  initial begin
    reset_ni = 1'b0; disp_valid_i = 1'b0; disp_load_i = 1'b0; disp_spec_i = 1'b0;
    disp_ld_tag_i = NO_VAL; disp_base_tag_i = NO_VAL; disp_data_tag_i = NO_VAL;
    disp_base_val_i = '0; disp_data_val_i = '0; disp_imm_i = '0;
    cdb_i = '0; cdb_load_i = '0; br_resolve_i = 1'b0; br_mispredict_i = 1'b0; lsu_read_i = 1'b0;
    tick(); tick();
    test_reset();
    reset_ni = 1'b1;
    tick();
    test_reset();
    test_load();
    test_store_snoop();
    test_full_wrap();
    test_squash();
    test_dispatch_capture();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
